// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding, the hold-register bundle and PC helpers.
package ifu_fetch_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic        fault;
    } hold_t;

    // Next sequential fetch address, always forced back onto a word boundary.
    function automatic logic [31:0] next_word(input logic [31:0] pc);
        return {pc[31:2] + 30'd1, 2'b00};
    endfunction

endpackage

// File: rtl/ifu_pc_reg.sv
// Fetch program counter with sequential advance and redirect load.
// Ports: clk, rst_n, advance (+4), redirect/redirect_pc (wins), pc.
module ifu_pc_reg
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else if (advance) begin
            pc <= next_word(pc);
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding word read, no prefetch.
// Ports: memory req/rsp, decode inst/pc/fault handshake, redirect in.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        ifu_req_valid_o,
    input  logic        ifu_req_ready_i,
    output logic [31:0] ifu_req_addr_o,
    input  logic        ifu_rsp_valid_i,
    input  logic [31:0] ifu_rsp_data_i,
    input  logic        ifu_rsp_err_i,
    output logic        ifu_inst_valid_o,
    input  logic        ifu_inst_ready_i,
    output logic [31:0] ifu_inst_o,
    output logic [31:0] ifu_pc_o,
    output logic        ifu_fault_o,
    input  logic        ifu_redirect_i,
    input  logic [31:0] ifu_redirect_pc_i
);

    fetch_state_e state;
    logic         kill;
    hold_t        hold;
    logic [31:0]  pc;

    logic misaligned;
    logic req_fire;
    logic inst_fire;
    logic in_wait;
    logic in_hold;

    assign misaligned = |ifu_redirect_pc_i[1:0];
    assign in_wait    = (state == S_WAIT);
    assign in_hold    = (state == S_HOLD);
    assign req_fire   = ifu_req_valid_o & ifu_req_ready_i;
    assign inst_fire  = ifu_inst_valid_o & ifu_inst_ready_i;

    // Gated by rst_n so the idle REQ state shows no request during reset.
    assign ifu_req_valid_o  = rst_n & (state == S_REQ);
    assign ifu_req_addr_o   = pc;
    // A redirect flushes the held entry, so it must never handshake.
    assign ifu_inst_valid_o = in_hold & ~ifu_redirect_i;
    assign ifu_inst_o       = in_hold ? hold.inst : NOP_INST;
    assign ifu_fault_o      = in_hold & hold.fault;
    assign ifu_pc_o         = pc;

    ifu_pc_reg #(
        .RESET_PC    (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .advance     (inst_fire),
        .redirect    (ifu_redirect_i),
        .redirect_pc (ifu_redirect_pc_i),
        .pc          (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
            kill  <= 1'b0;
            hold  <= '{inst: NOP_INST, fault: 1'b0};
        end else if (ifu_redirect_i) begin
            // kill tracks a read still in flight to the old stream;
            // a second redirect cannot add a second one.
            kill <= (kill & ~ifu_rsp_valid_i)
                  | req_fire
                  | (in_wait & ~ifu_rsp_valid_i);
            if (misaligned) begin
                state <= S_HOLD;
                hold  <= '{inst: NOP_INST, fault: 1'b1};
            end else if (req_fire || (in_wait && !ifu_rsp_valid_i)) begin
                state <= S_WAIT;
            end else begin
                state <= S_REQ;
            end
        end else begin
            // Any response retires the single outstanding read.
            if (ifu_rsp_valid_i) begin
                kill <= 1'b0;
            end
            unique case (state)
                S_REQ: begin
                    if (req_fire) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (ifu_rsp_valid_i) begin
                        if (kill) begin
                            state <= S_REQ;
                        end else begin
                            state <= S_HOLD;
                            hold  <= '{
                                inst:  ifu_rsp_err_i ? NOP_INST : ifu_rsp_data_i,
                                fault: ifu_rsp_err_i
                            };
                        end
                    end
                end
                S_HOLD: begin
                    if (inst_fire) begin
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: cycle table plus scoreboarded sequences.
// Memory responder and decode sink are modelled in the bench itself.
module tb_ifu_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fault;
    logic        redirect;
    logic [31:0] rpc;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ifu_req_valid_o   (req_valid),
        .ifu_req_ready_i   (req_ready),
        .ifu_req_addr_o    (req_addr),
        .ifu_rsp_valid_i   (rsp_valid),
        .ifu_rsp_data_i    (rsp_data),
        .ifu_rsp_err_i     (rsp_err),
        .ifu_inst_valid_o  (inst_valid),
        .ifu_inst_ready_i  (inst_ready),
        .ifu_inst_o        (inst),
        .ifu_pc_o          (pc),
        .ifu_fault_o       (fault),
        .ifu_redirect_i    (redirect),
        .ifu_redirect_pc_i (rpc)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    typedef struct {
        logic        ird;
        logic        rv;
        logic [31:0] ra;
        logic        iv;
        logic [31:0] inst;
        logic [31:0] pc;
    } row_t;

    exp_t        sbq[$];
    logic [31:0] rq[$];
    row_t        tbl[18];

    int errors = 0;
    int checks = 0;

    int          mem_lat  = 0;
    logic        pend     = 1'b0;
    int          cnt      = 0;
    logic [31:0] paddr    = 32'h0;
    logic [31:0] ovr_addr = 32'h1;
    logic [31:0] ovr_data = 32'h0;
    logic [31:0] err_addr = 32'h1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == ovr_addr) return ovr_data;
        if (a == 32'h8000_000C) return 32'h0050_0093;
        return a ^ 32'h5A5A_0033;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    // Sample point: memory accepts and decode handshakes are scored here.
    task automatic mid();
        @(negedge clk);
        if (rst_n && req_valid && req_ready) begin
            pend  = 1'b1;
            paddr = req_addr;
            cnt   = mem_lat;
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL req_extra: got %h required none", req_addr);
            end else begin
                chk("req_addr", req_addr, rq.pop_front());
            end
        end
        if (rst_n && inst_valid && inst_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL inst_extra: got %h pc %h required none",
                         inst, pc);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("inst", {inst, pc, fault}, {e.inst, e.pc, e.fault});
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else if (pend) begin
            if (cnt == 0) begin
                rsp_valid = 1'b1;
                rsp_data  = memfn(paddr);
                rsp_err   = (paddr == err_addr);
                pend      = 1'b0;
            end else begin
                cnt--;
            end
        end
        req_ready = (rq.size() != 0);
    endtask

    task automatic step();
        mid();
        tick();
    endtask

    task automatic upd_ready();
        req_ready = (rq.size() != 0);
    endtask

    task automatic redir(input logic [31:0] a);
        redirect = 1'b1;
        rpc      = a;
        step();
        redirect = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((sbq.size() != 0 || rq.size() != 0) && n < 80) begin
            step();
            n++;
        end
        checks++;
        if (n >= 80) begin
            errors++;
            $display("FAIL %s: inst %0d req %0d left, required 0 0",
                     nm, sbq.size(), rq.size());
            sbq.delete();
            rq.delete();
        end
    endtask

    task automatic park(input string nm, input logic [31:0] a);
        mid();
        chk(nm, {req_valid, req_addr, inst_valid}, {1'b1, a, 1'b0});
        tick();
    endtask

    task automatic chk_reset(input string nm);
        chk(nm, {req_valid, inst_valid, inst, fault, req_addr, pc},
            {1'b0, 1'b0, NOP, 1'b0, RPC, RPC});
    endtask

    task automatic expect_inst(input logic [31:0] a);
        sbq.push_back('{inst: memfn(a), pc: a, fault: 1'b0});
    endtask

    task automatic set_row(input int i, input logic ird, input logic rv,
                           input logic [31:0] ra, input logic iv,
                           input logic [31:0] ins, input logic [31:0] p);
        tbl[i] = '{ird: ird, rv: rv, ra: ra, iv: iv, inst: ins, pc: p};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        rsp_data   = 32'h0;
        rsp_err    = 1'b0;
        inst_ready = 1'b0;
        redirect   = 1'b0;
        rpc        = 32'h0;

        // Per-cycle trace after reset: REQ, WAIT, HOLD per fetch,
        // then a 5-cycle decode stall on the fourth word.
        set_row(0,  1, 1, RPC,      0, NOP,            RPC);
        set_row(1,  1, 0, RPC,      0, NOP,            RPC);
        set_row(2,  1, 0, RPC,      1, memfn(RPC),     RPC);
        set_row(3,  1, 1, RPC + 4,  0, NOP,            RPC + 4);
        set_row(4,  1, 0, RPC + 4,  0, NOP,            RPC + 4);
        set_row(5,  1, 0, RPC + 4,  1, memfn(RPC + 4), RPC + 4);
        set_row(6,  1, 1, RPC + 8,  0, NOP,            RPC + 8);
        set_row(7,  1, 0, RPC + 8,  0, NOP,            RPC + 8);
        set_row(8,  1, 0, RPC + 8,  1, memfn(RPC + 8), RPC + 8);
        set_row(9,  1, 1, RPC + 12, 0, NOP,            RPC + 12);
        set_row(10, 1, 0, RPC + 12, 0, NOP,            RPC + 12);
        for (int i = 11; i < 16; i++) begin
            set_row(i, 0, 0, RPC + 12, 1, 32'h0050_0093, RPC + 12);
        end
        set_row(16, 1, 0, RPC + 12, 1, 32'h0050_0093, RPC + 12);
        set_row(17, 1, 1, RPC + 16, 0, NOP,            RPC + 16);

        tick();
        chk_reset("reset_out");
        tick();

        for (int k = 0; k < 4; k++) begin
            rq.push_back(RPC + 32'(4 * k));
            expect_inst(RPC + 32'(4 * k));
        end
        upd_ready();
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            inst_ready = tbl[i].ird;
            mid();
            chk($sformatf("row%0d", i),
                {req_valid, req_addr, inst_valid, inst, pc},
                {tbl[i].rv, tbl[i].ra, tbl[i].iv, tbl[i].inst, tbl[i].pc});
            tick();
        end
        inst_ready = 1'b1;

        // bus error on one word, then sequential fetch resumes
        err_addr = 32'h8000_0010;
        rq.push_back(32'h8000_0010);
        rq.push_back(32'h8000_0014);
        sbq.push_back('{inst: NOP, pc: 32'h8000_0010, fault: 1'b1});
        expect_inst(32'h8000_0014);
        upd_ready();
        drain("drain_err");
        park("park_err", 32'h8000_0018);

        // redirect in WAIT, stale response arrives next cycle
        ovr_addr = 32'h8000_0018;
        ovr_data = 32'hDEAD_BEEF;
        mem_lat  = 1;
        rq.push_back(32'h8000_0018);
        rq.push_back(32'h8000_0100);
        expect_inst(32'h8000_0100);
        upd_ready();
        step();
        redir(32'h8000_0100);
        drain("drain_wait_redir");
        park("park_wait_redir", 32'h8000_0104);
        mem_lat = 0;

        // redirect in the same cycle as the response
        rq.push_back(32'h8000_0104);
        rq.push_back(32'h8000_0200);
        expect_inst(32'h8000_0200);
        upd_ready();
        step();
        redir(32'h8000_0200);
        drain("drain_rsp_redir");
        park("park_rsp_redir", 32'h8000_0204);

        // redirect in the same cycle decode would take the word
        rq.push_back(32'h8000_0204);
        rq.push_back(32'h8000_0300);
        expect_inst(32'h8000_0300);
        upd_ready();
        step();
        step();
        redirect = 1'b1;
        rpc      = 32'h8000_0300;
        mid();
        chk("hold_mask", inst_valid, 1'b0);
        tick();
        redirect = 1'b0;
        drain("drain_hold_redir");
        park("park_hold_redir", 32'h8000_0304);

        // misaligned redirect from REQ: fault without a memory read
        sbq.push_back('{inst: NOP, pc: 32'h8000_0102, fault: 1'b1});
        expect_inst(32'h8000_0104);
        rq.push_back(32'h8000_0104);
        redir(32'h8000_0102);
        drain("drain_misalign");
        park("park_misalign", 32'h8000_0108);

        // PC wrap past the top of the address space
        rq.push_back(32'hFFFF_FFFC);
        rq.push_back(32'h0000_0000);
        expect_inst(32'hFFFF_FFFC);
        expect_inst(32'h0000_0000);
        redir(32'hFFFF_FFFC);
        drain("drain_wrap");
        park("park_wrap", 32'h0000_0004);

        // redirect while the request is being accepted
        rq.push_back(32'h0000_0004);
        rq.push_back(32'h8000_0400);
        expect_inst(32'h8000_0400);
        upd_ready();
        redir(32'h8000_0400);
        drain("drain_acc_redir");
        park("park_acc_redir", 32'h8000_0404);

        // two redirects with one read in flight: exactly one discard
        mem_lat = 2;
        rq.push_back(32'h8000_0404);
        rq.push_back(32'h8000_0500);
        expect_inst(32'h8000_0500);
        upd_ready();
        redir(32'h8000_0480);
        redir(32'h8000_0500);
        drain("drain_double");
        park("park_double", 32'h8000_0504);

        // reset asserted while waiting on memory
        mem_lat = 3;
        rq.push_back(32'h8000_0504);
        upd_ready();
        step();
        rst_n = 1'b0;
        #1;
        chk_reset("reset_wait");
        mem_lat = 0;
        tick();
        tick();
        rst_n = 1'b1;
        rq.push_back(RPC);
        expect_inst(RPC);
        upd_ready();
        drain("drain_rerun");
        park("park_rerun", RPC + 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
